// File: rtl/part_select_unpacker_if.sv
// Valid/ready bundle for the word-in / field-out streaming unpacker.
// The master modport is the producer/consumer side, the slave modport is the unpacker.
interface part_select_unpacker_if #(
  parameter int WIDTH = 8,
  parameter int FW    = 3
);
  localparam int NFIELDS = (WIDTH + FW - 1) / FW;
  localparam int IW      = (NFIELDS > 1) ? $clog2(NFIELDS) : 1;

  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_data;
  logic             in_msb_first;
  logic             out_valid;
  logic             out_ready;
  logic [FW-1:0]    out_data;
  logic [IW-1:0]    out_idx;
  logic             out_last;

  modport master (
    output in_valid, in_data, in_msb_first, out_ready,
    input  in_ready, out_valid, out_data, out_idx, out_last
  );

  modport slave (
    input  in_valid, in_data, in_msb_first, out_ready,
    output in_ready, out_valid, out_data, out_idx, out_last
  );
endinterface

// File: rtl/part_select_unpacker.sv
// Streaming unpacker: captures a WIDTH-bit word and emits it as FW-bit fields,
// LSB-first or MSB-first per word, zero-padding the partial last field.
module part_select_unpacker #(
  parameter int WIDTH = 8,
  parameter int FW    = 3
) (
  input logic clk,
  input logic rst,
  part_select_unpacker_if.slave bus
);
  localparam int NFIELDS = (WIDTH + FW - 1) / FW;
  localparam int IW      = (NFIELDS > 1) ? $clog2(NFIELDS) : 1;
  localparam int EW      = NFIELDS * FW;
  localparam int OW      = $clog2(EW + 1);
  localparam logic [IW-1:0] LAST_IDX = IW'(NFIELDS - 1);

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    BUSY = 1'b1
  } state_t;

  state_t           state_r, state_s;
  logic [WIDTH-1:0] word_r, word_s;
  logic             mode_r, mode_s;
  logic [IW-1:0]    idx_r, idx_s;
  logic [IW-1:0]    sel_idx_s;
  logic [OW-1:0]    lo_s, hi_s;
  logic [EW-1:0]    ext_lsb_s, ext_msb_s;
  logic [FW-1:0]    field_s;
  logic             last_s;
  logic             ready_s;

  // Field decode from registered state only; the word is placed in a padded
  // buffer so every part-select stays inside its vector at any index.
  always_comb begin
    sel_idx_s = (idx_r > LAST_IDX) ? LAST_IDX : idx_r;
    lo_s      = OW'(sel_idx_s) * OW'(FW);
    hi_s      = OW'(EW - 1) - lo_s;
    ext_lsb_s = '0;
    ext_lsb_s[WIDTH-1:0] = word_r;
    ext_msb_s = '0;
    ext_msb_s[EW-1 -: WIDTH] = word_r;
    if (mode_r) begin
      field_s = ext_msb_s[hi_s -: FW];
    end else begin
      field_s = ext_lsb_s[lo_s +: FW];
    end
    last_s = (idx_r == LAST_IDX);
  end

  // Next-state logic; a word is also accepted on the last-field handshake.
  always_comb begin
    state_s = state_r;
    word_s  = word_r;
    mode_s  = mode_r;
    idx_s   = idx_r;
    ready_s = 1'b0;
    case (state_r)
      IDLE: begin
        ready_s = 1'b1;
        if (bus.in_valid) begin
          word_s  = bus.in_data;
          mode_s  = bus.in_msb_first;
          idx_s   = '0;
          state_s = BUSY;
        end else begin
          state_s = IDLE;
        end
      end
      BUSY: begin
        if (bus.out_ready) begin
          if (last_s) begin
            ready_s = 1'b1;
            if (bus.in_valid) begin
              word_s  = bus.in_data;
              mode_s  = bus.in_msb_first;
              idx_s   = '0;
              state_s = BUSY;
            end else begin
              state_s = IDLE;
            end
          end else begin
            idx_s = idx_r + IW'(1);
          end
        end else begin
          state_s = BUSY;
        end
      end
      default: begin
        state_s = IDLE;
        idx_s   = '0;
      end
    endcase
  end

  // State and datapath registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r <= IDLE;
      word_r  <= '0;
      mode_r  <= 1'b0;
      idx_r   <= '0;
    end else begin
      state_r <= state_s;
      word_r  <= word_s;
      mode_r  <= mode_s;
      idx_r   <= idx_s;
    end
  end

  assign bus.in_ready  = ready_s & ~rst;
  assign bus.out_valid = (state_r == BUSY);
  assign bus.out_data  = (state_r == BUSY) ? field_s : '0;
  assign bus.out_idx   = (state_r == BUSY) ? idx_r : '0;
  assign bus.out_last  = (state_r == BUSY) & last_s;
endmodule

// File: tb/tb_part_select_unpacker.sv
// Self-checking bench: three unpacker configurations checked against a queue
// model of the expected field stream, with directed and random stimulus.
module tb_part_select_unpacker;
  logic clk;
  logic rst;
  int   n_checks;
  int   n_fail;

  typedef struct {
    logic [31:0] data;
    logic [31:0] idx;
    logic        last;
  } exp_t;

  exp_t        q_a[$], q_b[$], q_c[$];
  logic [31:0] log_a[$], log_b[$], log_c[$];

  part_select_unpacker_if #(.WIDTH(8),  .FW(3))  if_a ();
  part_select_unpacker_if #(.WIDTH(12), .FW(4))  if_b ();
  part_select_unpacker_if #(.WIDTH(8),  .FW(10)) if_c ();

  part_select_unpacker #(.WIDTH(8),  .FW(3))  u_a (.clk(clk), .rst(rst), .bus(if_a));
  part_select_unpacker #(.WIDTH(12), .FW(4))  u_b (.clk(clk), .rst(rst), .bus(if_b));
  part_select_unpacker #(.WIDTH(8),  .FW(10)) u_c (.clk(clk), .rst(rst), .bus(if_c));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Field k of a word, from shifts and masks rather than part-selects.
  function automatic logic [31:0] field_of(input logic [31:0] w, input int width, input int fw,
                                           input int k, input logic msb);
    logic [63:0] mask;
    logic [63:0] ww;
    mask = (64'd1 << fw) - 64'd1;
    ww   = {32'd0, w};
    if (!msb) return 32'((ww >> (k * fw)) & mask);
    return 32'(((ww << fw) >> (width - k * fw)) & mask);
  endfunction

  task automatic monitor(input string tag, ref exp_t q[$], ref logic [31:0] log[$],
                         input int width, input int fw, input logic rst_v,
                         input logic iv, input logic ir, input logic imsb, input logic [31:0] idata,
                         input logic ov, input logic ordy, input logic [31:0] odata,
                         input logic [31:0] oidx, input logic olast);
    int   nf;
    exp_t e;
    nf = (width + fw - 1) / fw;
    if (rst_v) begin
      q.delete();
      check({tag, "_rst_in_ready"}, 64'(ir), 64'd0);
      check({tag, "_rst_out_valid"}, 64'(ov), 64'd0);
      check({tag, "_rst_out_data"}, 64'(odata), 64'd0);
      check({tag, "_rst_out_idx"}, 64'(oidx), 64'd0);
      check({tag, "_rst_out_last"}, 64'(olast), 64'd0);
    end else begin
      check({tag, "_out_valid"}, 64'(ov), 64'(q.size() != 0));
      if (ov && q.size() != 0) begin
        check({tag, "_out_data"}, 64'(odata), 64'(q[0].data));
        check({tag, "_out_idx"}, 64'(oidx), 64'(q[0].idx));
        check({tag, "_out_last"}, 64'(olast), 64'(q[0].last));
      end
      check({tag, "_in_ready"}, 64'(ir), 64'((q.size() == 0) || (ordy && q[0].last)));
      if (ov && ordy) begin
        log.push_back(odata);
        if (q.size() != 0) void'(q.pop_front());
      end
      if (iv && ir) begin
        for (int k = 0; k < nf; k++) begin
          e.data = field_of(idata, width, fw, k, imsb);
          e.idx  = 32'(k);
          e.last = (k == nf - 1);
          q.push_back(e);
        end
      end
    end
  endtask

  always @(negedge clk) begin
    monitor("a", q_a, log_a, 8, 3, rst, if_a.in_valid, if_a.in_ready, if_a.in_msb_first,
            32'(if_a.in_data), if_a.out_valid, if_a.out_ready, 32'(if_a.out_data),
            32'(if_a.out_idx), if_a.out_last);
    monitor("b", q_b, log_b, 12, 4, rst, if_b.in_valid, if_b.in_ready, if_b.in_msb_first,
            32'(if_b.in_data), if_b.out_valid, if_b.out_ready, 32'(if_b.out_data),
            32'(if_b.out_idx), if_b.out_last);
    monitor("c", q_c, log_c, 8, 10, rst, if_c.in_valid, if_c.in_ready, if_c.in_msb_first,
            32'(if_c.in_data), if_c.out_valid, if_c.out_ready, 32'(if_c.out_data),
            32'(if_c.out_idx), if_c.out_last);
  end

  task automatic check_log(input string tag, ref logic [31:0] log[$],
                           input logic [31:0] exp[6], input int n);
    check({tag, "_count"}, 64'(log.size()), 64'(n));
    for (int i = 0; i < n; i++) begin
      check($sformatf("%s_f%0d", tag, i),
            64'((i < log.size()) ? log[i] : 32'hDEAD_BEEF), 64'(exp[i]));
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    rst = 1'b1;
    if_a.in_valid = 1'b0; if_a.in_data = '0; if_a.in_msb_first = 1'b0; if_a.out_ready = 1'b0;
    if_b.in_valid = 1'b0; if_b.in_data = '0; if_b.in_msb_first = 1'b0; if_b.out_ready = 1'b0;
    if_c.in_valid = 1'b0; if_c.in_data = '0; if_c.in_msb_first = 1'b0; if_c.out_ready = 1'b0;
    repeat (3) @(posedge clk);
    #3 rst = 1'b0;
    #1;
    check("rel_a_in_ready", 64'(if_a.in_ready), 64'd1);
    check("rel_b_in_ready", 64'(if_b.in_ready), 64'd1);
    check("rel_c_in_ready", 64'(if_c.in_ready), 64'd1);
    tick(1);

    // LSB-first 8'hB5 in 3-bit fields
    log_a.delete();
    if_a.in_valid = 1'b1; if_a.in_data = 8'hB5; if_a.in_msb_first = 1'b0; if_a.out_ready = 1'b1;
    tick(1);
    if_a.in_valid = 1'b0;
    tick(5);
    check_log("t1_lsb", log_a, '{32'h5, 32'h6, 32'h2, 32'h0, 32'h0, 32'h0}, 3);

    // MSB-first, last field padded at the bottom
    log_a.delete();
    if_a.in_valid = 1'b1; if_a.in_msb_first = 1'b1;
    tick(1);
    if_a.in_valid = 1'b0;
    tick(5);
    check_log("t2_msb", log_a, '{32'h5, 32'h5, 32'h2, 32'h0, 32'h0, 32'h0}, 3);

    // Backpressure on field 1, second word taken on the last handshake
    log_b.delete();
    if_b.in_valid = 1'b1; if_b.in_data = 12'hABC; if_b.in_msb_first = 1'b0; if_b.out_ready = 1'b1;
    tick(1);
    if_b.in_data = 12'h123;
    tick(1);
    if_b.out_ready = 1'b0;
    tick(3);
    if_b.out_ready = 1'b1;
    tick(2);
    if_b.in_valid = 1'b0;
    tick(5);
    check_log("t3_bp", log_b, '{32'hC, 32'hB, 32'hA, 32'h3, 32'h2, 32'h1}, 6);

    // Single-field configuration, both orders back-to-back
    log_c.delete();
    if_c.in_valid = 1'b1; if_c.in_data = 8'hFF; if_c.in_msb_first = 1'b0; if_c.out_ready = 1'b1;
    tick(1);
    if_c.in_msb_first = 1'b1;
    tick(1);
    if_c.in_valid = 1'b0;
    tick(3);
    check_log("t4_single", log_c, '{32'h0FF, 32'h3FC, 32'h0, 32'h0, 32'h0, 32'h0}, 2);

    // Asynchronous reset after the first field
    log_a.delete();
    if_a.in_valid = 1'b1; if_a.in_data = 8'hB5; if_a.in_msb_first = 1'b0; if_a.out_ready = 1'b1;
    tick(1);
    if_a.in_valid = 1'b0;
    @(posedge clk);
    #3 rst = 1'b1;
    #1;
    check("t5_out_valid", 64'(if_a.out_valid), 64'd0);
    check("t5_out_data", 64'(if_a.out_data), 64'd0);
    check("t5_out_idx", 64'(if_a.out_idx), 64'd0);
    check("t5_in_ready", 64'(if_a.in_ready), 64'd0);
    @(posedge clk);
    #3 rst = 1'b0;
    #1;
    check("t5_rel_in_ready", 64'(if_a.in_ready), 64'd1);
    check("t5_rel_out_valid", 64'(if_a.out_valid), 64'd0);
    if_a.in_valid = 1'b1; if_a.in_data = 8'h07;
    tick(1);
    if_a.in_valid = 1'b0;
    tick(5);
    check_log("t5_rst", log_a, '{32'h5, 32'h7, 32'h0, 32'h0, 32'h0, 32'h0}, 4);

    // Order alternation between adjacent words
    log_a.delete();
    if_a.in_valid = 1'b1; if_a.in_data = 8'hB5; if_a.in_msb_first = 1'b1;
    tick(1);
    if_a.in_msb_first = 1'b0;
    tick(3);
    if_a.in_valid = 1'b0;
    tick(5);
    check_log("t6_alt", log_a, '{32'h5, 32'h5, 32'h2, 32'h5, 32'h6, 32'h2}, 6);

    // Random traffic on all three configurations
    for (int cyc = 0; cyc < 3000; cyc++) begin
      if_a.in_valid = ($urandom_range(0, 3) != 0); if_a.in_data = 8'($urandom);
      if_a.in_msb_first = 1'($urandom); if_a.out_ready = ($urandom_range(0, 3) != 0);
      if_b.in_valid = ($urandom_range(0, 3) != 0); if_b.in_data = 12'($urandom);
      if_b.in_msb_first = 1'($urandom); if_b.out_ready = ($urandom_range(0, 3) != 0);
      if_c.in_valid = ($urandom_range(0, 3) != 0); if_c.in_data = 8'($urandom);
      if_c.in_msb_first = 1'($urandom); if_c.out_ready = ($urandom_range(0, 3) != 0);
      tick(1);
    end
    if_a.in_valid = 1'b0; if_a.out_ready = 1'b1;
    if_b.in_valid = 1'b0; if_b.out_ready = 1'b1;
    if_c.in_valid = 1'b0; if_c.out_ready = 1'b1;
    tick(10);
    check("drain_a", 64'(q_a.size()), 64'd0);
    check("drain_b", 64'(q_b.size()), 64'd0);
    check("drain_c", 64'(q_c.size()), 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end
endmodule
